mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Holds the MAR/MDR pair and runs multi-cycle SRAM read/write transactions for the SLC-3 datapath.
- Upstream: the bus/MARMUX selection muxes feed Bus_in.
- Downstream: MDR feeds the GateMDR bus-gating mux.
- The control unit (ISDU) issues Mem_req and waits on R before advancing.

Parameters:
- WIDTH, 16, data and address width.
- WAIT_STATES, 2, SRAM access cycles per transaction (legal range 1..15).

Ports:
- Clk  in  1  system clock, rising-edge.
- Reset  in  1  asynchronous, active-high reset.
- Bus_in  in  WIDTH  datapath bus value.
- LD_MAR  in  1  load MAR from Bus_in.
- LD_MDR  in  1  load MDR from Bus_in.
- Mem_req  in  1  start a transaction, sampled in IDLE only.
- Mem_rw  in  1  1 = write, 0 = read, sampled with Mem_req.
- SRAM_data_in  in  WIDTH  read data from SRAM.
- MAR  out  WIDTH  memory address register.
- MDR  out  WIDTH  memory data register.
- SRAM_addr  out  WIDTH  address to SRAM (= MAR).
- SRAM_data_out  out  WIDTH  write data to SRAM (= MDR).
- CE_n  out  1  chip enable, active-low.
- OE_n  out  1  output enable, active-low.
- WE_n  out  1  write enable, active-low.
- R  out  1  transaction complete, one-cycle pulse.
- Busy  out  1  high in WAIT and DONE.

Behaviour:
- Reset (async, immediate):
  - MAR = 0, MDR = 0, state = IDLE, counter = 0, latched rw = 0.
  - CE_n = OE_n = WE_n = 1, R = 0, Busy = 0.
- States: IDLE, WAIT, DONE. All strobes, R and Busy decode combinationally from state and latched rw.
- IDLE:
  - LD_MAR loads MAR from Bus_in.
  - LD_MDR loads MDR from Bus_in.
  - Both may assert in the same cycle; both registers load.
  - Mem_req = 1 at a rising edge: latch Mem_rw, counter <= 0, go to WAIT.
  - A load and Mem_req in the same cycle: the register loads at that edge, and the transaction uses the new value.
- WAIT:
  - Lasts exactly WAIT_STATES cycles. Counter increments each edge.
  - When counter = WAIT_STATES-1 at an edge, go to DONE.
  - CE_n = 0 throughout.
  - Read: OE_n = 0, WE_n = 1. On the final WAIT edge, MDR <= SRAM_data_in.
  - Write: OE_n = 1, WE_n = 0.
  - MAR and MDR stay stable during writes.
- DONE:
  - Lasts one cycle with R = 1 and all strobes deasserted (= 1), then IDLE.
- Latency: Mem_req sampled at edge E0, R high in the cycle after edge E(WAIT_STATES).
  - WAIT_STATES = 2: R is high 2 cycles after the request edge; 3 cycles total to IDLE.
- While Busy:
  - LD_MAR, LD_MDR and Mem_req are ignored; no queuing.
  - A request held high through DONE starts a new transaction at the first IDLE edge.
- Mem_rw changes after acceptance have no effect.
- Reset mid-transaction:
  - Strobes deassert asynchronously.
  - MDR clears, and the partial read is discarded.
  - R is never pulsed.
- Counter width: 4 bits, no wrap (bounded by WAIT_STATES ≤ 15).
- SRAM_addr and SRAM_data_out are continuously driven from MAR and MDR in every state.

Decomposition:
- Package slc3_mem_pkg:
  - mem_state_t enum {IDLE, WAIT, DONE}.
  - Constants MEM_READ = 0, MEM_WRITE = 1.
  - Default WAIT_STATES.
- Sub-module mem_wait_counter:
  - Parameterised terminal count with clear, enable and terminal-count outputs.
  - Same Clk/Reset convention.

Test Plan:
- Read: Reset; Bus_in = 16'h3000 with LD_MAR; SRAM_data_in = 16'hBEEF; Mem_req with Mem_rw = 0 → CE_n and OE_n low for 2 cycles, WE_n = 1, MDR = 16'hBEEF and R = 1 on the 3rd cycle, then IDLE.
- Write: MAR = 16'h0010, MDR = 16'h1234 via LD_MDR; Mem_req with Mem_rw = 1 → WE_n low for exactly 2 cycles, OE_n = 1, SRAM_addr = 16'h0010, SRAM_data_out = 16'h1234, single R pulse.
- Busy guarding: LD_MAR with Bus_in = 16'hFFFF during WAIT → MAR unchanged; a second Mem_req pulse during WAIT → exactly one R pulse.
- Same-cycle load and request: LD_MAR with Bus_in = 16'h4000 and Mem_req asserted together → SRAM_addr = 16'h4000 throughout WAIT.
- Reset mid-read: Reset asserted in the 1st WAIT cycle → CE_n/OE_n = 1 immediately (before the next edge), MDR = 0, no R; the next request completes normally.
- WAIT_STATES = 1 instance: read completes with R high one cycle after the request edge.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the SLC-3 memory access controller.
// Contents:
//   mem_state_t          - transaction FSM states (IDLE, WAIT, DONE)
//   MEM_READ / MEM_WRITE - encoding of the Mem_rw request qualifier
//   DEFAULT_WAIT_STATES  - SRAM access cycles per transaction
//   CNT_W                - width of the wait-state counter
package slc3_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    localparam int unsigned DEFAULT_WAIT_STATES = 2;
    localparam int unsigned CNT_W               = 4;

endpackage

// File: rtl/mem_access_ctrl_wait_counter.sv
// Wait-state counter for SRAM transactions.
// Ports:
//   Clk    - rising-edge clock
//   Reset  - asynchronous active-high reset, clears the count
//   i_clr  - synchronous clear (start of a transaction)
//   i_en   - count enable (one increment per edge while enabled)
//   o_tc   - terminal count reached (count == TERMINAL-1)
module mem_wait_counter
    import slc3_mem_pkg::*;
#(
    parameter int unsigned TERMINAL = DEFAULT_WAIT_STATES
) (
    input  logic Clk,
    input  logic Reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TERMINAL - 1);

    logic [CNT_W-1:0] r_count;

    if (TERMINAL < 1 || TERMINAL > 15) begin : g_bad_terminal
        $error("mem_wait_counter: TERMINAL must be in 1..15");
    end

    // Holding at the terminal value keeps the counter from wrapping.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && !o_tc) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tc = (r_count == TC_VAL);

endmodule

// File: rtl/mem_access_ctrl.sv
// MAR/MDR register pair and multi-cycle SRAM read/write sequencer.
// Ports:
//   Clk, Reset      - rising-edge clock, asynchronous active-high reset
//   Bus_in          - datapath bus, source for MAR/MDR loads
//   LD_MAR, LD_MDR  - register load strobes (honoured in IDLE only)
//   Mem_req, Mem_rw - transaction request and direction (1 = write)
//   SRAM_data_in    - read data from SRAM
//   MAR, MDR        - address / data registers
//   SRAM_addr       - = MAR;  SRAM_data_out - = MDR
//   CE_n, OE_n, WE_n- active-low SRAM strobes
//   R               - one-cycle transaction-complete pulse
//   Busy            - high while a transaction is in flight (WAIT/DONE)
module mem_access_ctrl
    import slc3_mem_pkg::*;
#(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned WAIT_STATES = DEFAULT_WAIT_STATES
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Bus_in,
    input  logic             LD_MAR,
    input  logic             LD_MDR,
    input  logic             Mem_req,
    input  logic             Mem_rw,
    input  logic [WIDTH-1:0] SRAM_data_in,
    output logic [WIDTH-1:0] MAR,
    output logic [WIDTH-1:0] MDR,
    output logic [WIDTH-1:0] SRAM_addr,
    output logic [WIDTH-1:0] SRAM_data_out,
    output logic             CE_n,
    output logic             OE_n,
    output logic             WE_n,
    output logic             R,
    output logic             Busy
);

    mem_state_t       r_state;
    logic             r_rw;
    logic [WIDTH-1:0] r_mar;
    logic [WIDTH-1:0] r_mdr;

    logic w_start;
    logic w_in_wait;
    logic w_tc;

    assign w_start   = (r_state == IDLE) && Mem_req;
    assign w_in_wait = (r_state == WAIT);

    mem_wait_counter #(
        .TERMINAL (WAIT_STATES)
    ) u_wait_counter (
        .Clk   (Clk),
        .Reset (Reset),
        .i_clr (w_start),
        .i_en  (w_in_wait),
        .o_tc  (w_tc)
    );

    // Loads in IDLE take effect on the same edge that accepts a request,
    // so the transaction drives the freshly loaded MAR/MDR.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
            r_rw    <= MEM_READ;
            r_mar   <= '0;
            r_mdr   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (LD_MAR) r_mar <= Bus_in;
                    if (LD_MDR) r_mdr <= Bus_in;
                    if (Mem_req) begin
                        r_rw    <= Mem_rw;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (w_tc) begin
                        r_state <= DONE;
                        if (r_rw == MEM_READ) r_mdr <= SRAM_data_in;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        CE_n = 1'b1;
        OE_n = 1'b1;
        WE_n = 1'b1;
        R    = 1'b0;
        Busy = 1'b0;
        case (r_state)
            WAIT: begin
                CE_n = 1'b0;
                OE_n = (r_rw != MEM_READ);
                WE_n = (r_rw != MEM_WRITE);
                Busy = 1'b1;
            end
            DONE: begin
                R    = 1'b1;
                Busy = 1'b1;
            end
            default: ;
        endcase
    end

    assign MAR           = r_mar;
    assign MDR           = r_mdr;
    assign SRAM_addr     = r_mar;
    assign SRAM_data_out = r_mdr;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] Bus_in = '0;
    logic        LD_MAR = 1'b0;
    logic        LD_MDR = 1'b0;
    logic        Mem_req = 1'b0;
    logic        Mem_rw = 1'b0;
    logic [15:0] SRAM_data_in = '0;

    logic [15:0] mar0, mdr0, addr0, dout0, mar1, mdr1, addr1, dout1;
    logic        ce0, oe0, we0, r0, busy0, ce1, oe1, we1, r1, busy1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    mem_access_ctrl #(.WIDTH(16), .WAIT_STATES(2)) dut2 (
        .Clk(Clk), .Reset(Reset), .Bus_in(Bus_in), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR),
        .Mem_req(Mem_req), .Mem_rw(Mem_rw), .SRAM_data_in(SRAM_data_in),
        .MAR(mar0), .MDR(mdr0), .SRAM_addr(addr0), .SRAM_data_out(dout0),
        .CE_n(ce0), .OE_n(oe0), .WE_n(we0), .R(r0), .Busy(busy0)
    );

    mem_access_ctrl #(.WIDTH(16), .WAIT_STATES(1)) dut1 (
        .Clk(Clk), .Reset(Reset), .Bus_in(Bus_in), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR),
        .Mem_req(Mem_req), .Mem_rw(Mem_rw), .SRAM_data_in(SRAM_data_in),
        .MAR(mar1), .MDR(mdr1), .SRAM_addr(addr1), .SRAM_data_out(dout1),
        .CE_n(ce1), .OE_n(oe1), .WE_n(we1), .R(r1), .Busy(busy1)
    );

    // Transaction-level model: phase 0 = idle, 1..ws = access cycles,
    // ws+1 = completion cycle.
    int          ws[2] = '{2, 1};
    logic [15:0] m_mar[2] = '{16'h0, 16'h0};
    logic [15:0] m_mdr[2] = '{16'h0, 16'h0};
    logic        m_rw[2]  = '{1'b0, 1'b0};
    int          m_ph[2]  = '{0, 0};

    always @(posedge Clk or posedge Reset) begin
        for (int i = 0; i < 2; i++) begin
            if (Reset) begin
                m_mar[i] = '0; m_mdr[i] = '0; m_rw[i] = 1'b0; m_ph[i] = 0;
            end else if (m_ph[i] == 0) begin
                if (LD_MAR) m_mar[i] = Bus_in;
                if (LD_MDR) m_mdr[i] = Bus_in;
                if (Mem_req) begin m_rw[i] = Mem_rw; m_ph[i] = 1; end
            end else if (m_ph[i] <= ws[i]) begin
                if (m_ph[i] == ws[i] && !m_rw[i]) m_mdr[i] = SRAM_data_in;
                m_ph[i] = m_ph[i] + 1;
            end else begin
                m_ph[i] = 0;
            end
        end
    end

    function automatic logic [68:0] expv(int i);
        logic acc, fin;
        acc = (m_ph[i] >= 1) && (m_ph[i] <= ws[i]);
        fin = (m_ph[i] == ws[i] + 1);
        return {m_mar[i], m_mdr[i], m_mar[i], m_mdr[i],
                !acc, !(acc && !m_rw[i]), !(acc && m_rw[i]), fin, acc || fin};
    endfunction

    logic [68:0] obs[2];
    assign obs[0] = {mar0, mdr0, addr0, dout0, ce0, oe0, we0, r0, busy0};
    assign obs[1] = {mar1, mdr1, addr1, dout1, ce1, oe1, we1, r1, busy1};

    always @(negedge Clk) begin
        if (!Reset) begin
            for (int i = 0; i < 2; i++) begin
                logic [68:0] e;
                e = expv(i);
                n_cmp++;
                if (obs[i] !== e) begin
                    n_err++;
                    $display("FAIL model_ws%0d t=%0t got {MAR,MDR,ADDR,DOUT,CE,OE,WE,R,BUSY}=%h required %h",
                             ws[i], $time, obs[i], e);
                end
            end
        end
    end

    task automatic lit(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got %h required %h", nm, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    task automatic idle_inputs();
        LD_MAR = 1'b0; LD_MDR = 1'b0; Mem_req = 1'b0; Mem_rw = 1'b0;
    endtask

    initial begin
        #2;
        lit("rst_mar", mar0, 16'h0);
        lit("rst_mdr", mdr0, 16'h0);
        lit("rst_strobes", {13'b0, ce0, oe0, we0}, 16'h7);
        lit("rst_r_busy", {14'b0, r0, busy0}, 16'h0);
        tick(); tick();
        Reset = 1'b0;
        tick();

        // Read
        Bus_in = 16'h3000; LD_MAR = 1'b1; SRAM_data_in = 16'hBEEF;
        tick();
        LD_MAR = 1'b0; Mem_req = 1'b1; Mem_rw = 1'b0;
        tick();
        idle_inputs();
        lit("rd_w1_strobes", {13'b0, ce0, oe0, we0}, 16'h1);
        lit("rd_addr", addr0, 16'h3000);
        lit("rd_w1_r", {15'b0, r0}, 16'h0);
        tick();
        lit("rd_w2_strobes", {13'b0, ce0, oe0, we0}, 16'h1);
        lit("rd_ws1_r", {15'b0, r1}, 16'h1);
        lit("rd_ws1_mdr", mdr1, 16'hBEEF);
        tick();
        lit("rd_done_r", {15'b0, r0}, 16'h1);
        lit("rd_done_mdr", mdr0, 16'hBEEF);
        lit("rd_done_strobes", {13'b0, ce0, oe0, we0}, 16'h7);
        tick();
        lit("rd_idle", {14'b0, r0, busy0}, 16'h0);

        // Write
        Bus_in = 16'h0010; LD_MAR = 1'b1;
        tick();
        LD_MAR = 1'b0; Bus_in = 16'h1234; LD_MDR = 1'b1;
        tick();
        LD_MDR = 1'b0; Mem_req = 1'b1; Mem_rw = 1'b1;
        tick();
        idle_inputs();
        lit("wr_w1_strobes", {13'b0, ce0, oe0, we0}, 16'h2);
        lit("wr_addr", addr0, 16'h0010);
        lit("wr_dout", dout0, 16'h1234);
        tick();
        lit("wr_w2_strobes", {13'b0, ce0, oe0, we0}, 16'h2);
        tick();
        lit("wr_done", {13'b0, we0, r0, 1'b0}, 16'h6);
        lit("wr_mdr_kept", mdr0, 16'h1234);
        tick();

        // Busy guarding
        Mem_req = 1'b1; Mem_rw = 1'b0;
        tick();
        Bus_in = 16'hFFFF; LD_MAR = 1'b1; Mem_req = 1'b1;
        tick();
        idle_inputs();
        tick();
        lit("busy_mar", mar0, 16'h0010);
        lit("busy_r", {15'b0, r0}, 16'h1);
        tick();
        lit("busy_one_r", {14'b0, r0, busy0}, 16'h0);
        tick();

        // Same-cycle load and request
        Bus_in = 16'h4000; LD_MAR = 1'b1; Mem_req = 1'b1; Mem_rw = 1'b0;
        tick();
        idle_inputs();
        lit("same_w1_addr", addr0, 16'h4000);
        tick();
        lit("same_w2_addr", addr0, 16'h4000);
        tick(); tick();

        // Reset mid-read
        SRAM_data_in = 16'h5A5A; Mem_req = 1'b1; Mem_rw = 1'b0;
        tick();
        idle_inputs();
        Reset = 1'b1;
        #1;
        lit("mid_rst_strobes", {13'b0, ce0, oe0, we0}, 16'h7);
        lit("mid_rst_mdr", mdr0, 16'h0);
        lit("mid_rst_busy", {14'b0, r0, busy0}, 16'h0);
        #1;
        Reset = 1'b0;
        tick(); tick();
        lit("mid_rst_no_r", {15'b0, r0}, 16'h0);
        Mem_req = 1'b1;
        tick();
        idle_inputs();
        tick(); tick();
        lit("after_rst_r", {15'b0, r0}, 16'h1);
        lit("after_rst_mdr", mdr0, 16'h5A5A);
        tick();

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            Bus_in       = 16'($urandom);
            SRAM_data_in = 16'($urandom);
            LD_MAR       = ($urandom_range(0, 3) == 0);
            LD_MDR       = ($urandom_range(0, 3) == 0);
            Mem_req      = ($urandom_range(0, 2) == 0);
            Mem_rw       = 1'($urandom);
            if ($urandom_range(0, 149) == 0) begin
                Reset = 1'b1;
                #1;
                Reset = 1'b0;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
